store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the datapath's store path and the 16-bit data memory. Accepts stores from the execute stage in one cycle, queues them in a small FIFO, and drains them to the memory write port one per cycle whenever the memory is not busy with a load. Loads check the buffer in the same cycle and get the youngest matching pending store, so buffered writes are never observed stale.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥ 2
- AW, 16, address width
- DW, 16, data width

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from datapath
- st_addr  in  AW  store address
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_req  in  1  datapath load this cycle
- ld_addr  in  AW  load address
- ld_hit  out  1  a pending entry matches ld_addr
- ld_data  out  DW  data of youngest matching entry, 0 if no hit
- mem_busy  in  1  memory port is used by a load this cycle; blocks drain
- mem_we  out  1  write strobe to data memory
- mem_a  out  AW  write address to data memory
- mem_wd  out  DW  write data to data memory
- drain  in  1  level; block new stores until buffer is empty (halt/sync)
- count  out  $clog2(DEPTH+1)  occupied entries
- idle  out  1  count == 0

## Operation
- Storage: circular FIFO of DEPTH entries {addr, data}; head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; separate registered count.
- Push: occurs when st_valid & st_ready. st_ready = (count != DEPTH) & ~drain. A full buffer accepts no store, even if a pop happens the same cycle (no pass-through). When st_valid is asserted and st_ready is low, the store is not taken; the datapath stalls and holds the request.
- Pop/drain: mem_we = (count != 0) & ~mem_busy. mem_a and mem_wd always show the head entry. When count is 0 they show the last head contents, or 0 after reset. Head advances at the edge when mem_we = 1.
- Loads have priority over drain through mem_busy. The block has no internal starvation guard; mem_busy must deassert eventually.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Forwarding, combinational:
  - Compare ld_addr against all valid entries, full AW bits.
  - ld_hit = ld_req & any match. ld_data = youngest match (closest to tail).
  - An entry being popped this cycle is still valid and forwardable.
  - A store being pushed in the same cycle is not forwarded.
  - ld_hit = 0 and ld_data = 0 when ld_req = 0.
- Ordering: stores reach memory in program order. Repeated stores to the same address are not merged.
- drain only gates st_ready. Draining proceeds normally, and idle rises when the last entry pops.

## Timing
- Reset, synchronous, takes priority over all inputs:
  - count = 0, head = tail = 0, entries cleared to 0.
  - Outputs: st_ready = 1 (if drain = 0), idle = 1, mem_we = 0, mem_a = mem_wd = 0, ld_hit = 0, ld_data = 0.
- Reset mid-operation: all pending stores are discarded and no mem_we is issued in the reset cycle.
- Store accepted at edge N: the entry is visible to forwarding and to the head from cycle N+1. The earliest mem_we for it is cycle N+1, so minimum store-to-memory latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained.
- mem_we, mem_a, mem_wd and ld_hit/ld_data are combinational from registered state plus mem_busy and ld_addr. There are no other combinational input-to-output paths except st_ready from drain.

## Test plan
- Reset then single store: push (0x0005, 0xABCD) at cycle 0 with mem_busy = 0 → cycle 1 shows mem_we = 1, mem_a = 0x0005, mem_wd = 0xABCD; cycle 2 shows idle = 1, count = 0.
- Fill with mem_busy = 1: push addresses 1,2,3,4 → count = 4, st_ready = 0. A 5th st_valid is not taken. Release mem_busy → four consecutive mem_we in order 1,2,3,4.
- Forwarding: buffer holds (0x10, 0x1111) then (0x10, 0x2222), mem_busy = 1 → ld_req at 0x10 gives ld_hit = 1, ld_data = 0x2222. Load at 0x11 gives ld_hit = 0, ld_data = 0.
- Simultaneous push/pop at count = 2 → count stays 2, FIFO order preserved across pointer wrap (≥ 8 pushes total).
- drain = 1 with 3 entries → st_ready = 0 throughout, 3 writes issued, idle = 1, st_ready returns to 1 only after drain drops.
- rst asserted with count = 3 → next cycle count = 0, mem_we = 0, the discarded entries are never written.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write buffer between the store path and the 16-bit
//               data memory. Queues stores in a circular FIFO, drains one
//               per cycle when the memory port is free, and forwards the
//               youngest matching pending store to same-cycle loads.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  input  logic          mem_busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic          drain,
  output logic [CW-1:0] count,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);

  // Entry storage and FIFO bookkeeping
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  // Copy of the most recently popped entry, shown on the write port when empty
  logic [AW-1:0] last_a_q, last_a_d;
  logic [DW-1:0] last_d_q, last_d_d;

  logic push;
  logic pop;
  logic not_empty;

  // Handshake and memory write port; the write is suppressed during reset
  always_comb begin
    not_empty = (count_q != '0);
    st_ready  = (count_q != CW'(DEPTH)) & ~drain;
    mem_we    = not_empty & ~mem_busy & ~rst;
    push      = st_valid & st_ready;
    pop       = mem_we;
    mem_a     = not_empty ? addr_q[head_q] : last_a_q;
    mem_wd    = not_empty ? data_q[head_q] : last_d_q;
    count     = count_q;
    idle      = ~not_empty;
  end

  // Load forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_req && (CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[head_q + PW'(i)];
      end
    end
  end

  // Next-state computation for pointers, count and entry contents
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    last_a_d = last_a_q;
    last_d_d = last_d_q;
    if (push) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      last_a_d = addr_q[head_q];
      last_d_d = data_q[head_q];
      head_d   = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all pending stores
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      last_a_q <= '0;
      last_d_q <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      last_a_q <= last_a_d;
      last_d_q <= last_d_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer; a queue-based model of
//               pending stores predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_busy;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          drain;
  logic [CW-1:0] count;
  logic          idle;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .mem_busy (mem_busy),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .drain    (drain),
    .count    (count),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Model state: pending stores in program order, plus the last written entry
  ent_t          mq[$];
  logic [AW-1:0] m_last_a = '0;
  logic [DW-1:0] m_last_d = '0;
  // Every store the model expects to reach memory, in order
  ent_t          wq[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model
  task automatic step(input logic r, input logic sv, input logic [AW-1:0] sa,
                      input logic [DW-1:0] sd, input logic lr, input logic [AW-1:0] la,
                      input logic busy, input logic drn);
    logic          e_ready, e_we, e_hit;
    logic [DW-1:0] e_ldd;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    int            n;
    @(negedge clk);
    rst = r; st_valid = sv; st_addr = sa; st_data = sd;
    ld_req = lr; ld_addr = la; mem_busy = busy; drain = drn;
    #1;
    n       = mq.size();
    e_ready = (n != DEPTH) && !drn;
    e_we    = !r && (n != 0) && !busy;
    e_hit   = 1'b0;
    e_ldd   = '0;
    if (lr) begin
      foreach (mq[k]) begin
        if (mq[k].a == la) begin
          e_hit = 1'b1;
          e_ldd = mq[k].d;
        end
      end
    end
    e_a = (n != 0) ? mq[0].a : m_last_a;
    e_d = (n != 0) ? mq[0].d : m_last_d;
    check("st_ready", 32'(st_ready), 32'(e_ready));
    check("mem_we",   32'(mem_we),   32'(e_we));
    check("mem_a",    32'(mem_a),    32'(e_a));
    check("mem_wd",   32'(mem_wd),   32'(e_d));
    check("ld_hit",   32'(ld_hit),   32'(e_hit));
    check("ld_data",  32'(ld_data),  32'(e_ldd));
    check("count",    32'(count),    32'(n));
    check("idle",     32'(idle),     32'(n == 0));
    if (mem_we) begin
      if (wq.size() == 0) check("write_order_extra", 32'(mem_a), 32'hFFFF_FFFF);
      else begin
        check("write_order_a", 32'(mem_a),  32'(wq[0].a));
        check("write_order_d", 32'(mem_wd), 32'(wq[0].d));
        void'(wq.pop_front());
      end
    end
    if (r) begin
      mq.delete();
      wq.delete();
      m_last_a = '0;
      m_last_d = '0;
    end else begin
      if (e_we) begin
        m_last_a = mq[0].a;
        m_last_d = mq[0].d;
        void'(mq.pop_front());
      end
      if (sv && e_ready) begin
        mq.push_back('{a: sa, d: sd});
        wq.push_back('{a: sa, d: sd});
      end
    end
  endtask

  task automatic idle_step(input logic busy);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_addr = '0; mem_busy = 1'b0; drain = 1'b0;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle_step(1'b0);

    // Single store, one-cycle latency to memory
    step(1'b0, 1'b1, 16'h0005, 16'hABCD, 1'b0, '0, 1'b0, 1'b0);
    idle_step(1'b0);
    idle_step(1'b0);

    // Fill while memory busy, fifth store refused, then drain in order
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b1, 16'(i), 16'(16'h1000 + i), 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle_step(1'b0);

    // Forwarding: youngest match wins, miss returns zero
    step(1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0010, 16'h2222, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 16'h0010, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 16'h0011, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0011, 16'h3333, 1'b1, 16'h0011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle_step(1'b0);

    // Simultaneous push/pop at count 2 across pointer wrap
    step(1'b0, 1'b1, 16'h0020, 16'h0A00, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0021, 16'h0A01, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 2; i < 12; i++)
      step(1'b0, 1'b1, 16'(16'h0020 + i), 16'(16'h0A00 + i), 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_step(1'b0);

    // Drain blocks new stores until empty
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'(16'h0030 + i), 16'(16'h0B00 + i), 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 16'h0040, 16'h0C00, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0041, 16'h0C01, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) idle_step(1'b0);

    // Reset with pending stores discards them
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'(16'h0050 + i), 16'(16'h0D00 + i), 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_step(1'b0);

    // Randomized traffic over a small address range to exercise forwarding
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 60),
           16'($urandom_range(0, 7)),
           16'($urandom),
           ($urandom_range(0, 99) < 50),
           16'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
